// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM state encoding, parity modes and the parity-bit helper.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // ones_xor is the XOR of all data bits; the result makes data+parity odd or even
    function automatic logic parity_bit(input logic ones_xor, input int mode);
        logic bit_v;
        case (mode)
            PAR_ODD:  bit_v = ~ones_xor;
            PAR_EVEN: bit_v = ones_xor;
            default:  bit_v = 1'b1;
        endcase
        return bit_v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count and first-word-fall-through read data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO: configurable word length, parity and stop bits, back-to-back frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk48,
    input  logic                          rst_n,
    input  logic                          i_TX_DV,
    input  logic [DATA_BITS-1:0]          i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic                          o_TX_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Active,
    output logic                          o_TX_Done
);

    localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO  = {BAUD_W{1'b0}};
    localparam logic [2:0]        DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST  = 3'(STOP_BITS - 1);
    localparam bit                HAS_PARITY = (PARITY != PAR_NONE);

    tx_state_t             state_r, state_s;
    logic [BAUD_W-1:0]     baud_r, baud_s;
    logic [2:0]            bit_r, bit_s;
    logic [DATA_BITS-1:0]  shreg_r, shreg_s;
    logic                  par_r, par_s;
    logic                  serial_r, serial_s;
    logic                  active_r, active_s;
    logic                  done_r, done_s;
    logic                  avail_r;
    logic                  ovf_r;
    logic                  pop_s;
    logic                  baud_end_s;
    logic [DATA_BITS-1:0]  fifo_dout_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk48),
        .rst_n (rst_n),
        .push  (i_TX_DV),
        .din   (i_TX_Byte),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .count (o_FIFO_Count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign baud_end_s    = (baud_r == BAUD_LAST);
    assign o_TX_Ready    = !fifo_full_s;
    assign o_TX_Overflow = ovf_r;
    assign o_TX_Serial   = serial_r;
    assign o_TX_Active   = active_r;
    assign o_TX_Done     = done_r;

    // Next-state logic; line outputs are decoded from the next state so the flops track the FSM exactly
    always_comb begin
        state_s = state_r;
        bit_s   = bit_r;
        shreg_s = shreg_r;
        par_s   = par_r;
        pop_s   = 1'b0;
        if (state_r == TX_IDLE) begin
            baud_s = BAUD_ZERO;
        end else begin
            baud_s = baud_end_s ? BAUD_ZERO : baud_r + BAUD_W'(1'b1);
        end

        case (state_r)
            TX_IDLE: begin
                // avail_r adds one cycle of registration before the first pop out of idle
                if (avail_r && !fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shreg_s = fifo_dout_s;
                    par_s   = 1'b0;
                    bit_s   = 3'd0;
                    state_s = TX_START;
                end else begin
                    state_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (baud_end_s) begin
                    bit_s   = 3'd0;
                    state_s = TX_DATA;
                end else begin
                    state_s = TX_START;
                end
            end
            TX_DATA: begin
                if (baud_end_s) begin
                    par_s   = par_r ^ shreg_r[0];
                    shreg_s = shreg_r >> 1;
                    if (bit_r == DATA_LAST) begin
                        bit_s   = 3'd0;
                        state_s = HAS_PARITY ? TX_PARITY : TX_STOP;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                    end
                end else begin
                    state_s = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (baud_end_s) begin
                    bit_s   = 3'd0;
                    state_s = TX_STOP;
                end else begin
                    state_s = TX_PARITY;
                end
            end
            TX_STOP: begin
                if (baud_end_s && (bit_r == STOP_LAST)) begin
                    if (avail_r && !fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shreg_s = fifo_dout_s;
                        par_s   = 1'b0;
                        bit_s   = 3'd0;
                        state_s = TX_START;
                    end else begin
                        state_s = TX_IDLE;
                    end
                end else if (baud_end_s) begin
                    bit_s = bit_r + 3'd1;
                end else begin
                    state_s = TX_STOP;
                end
            end
            default: begin
                state_s = TX_IDLE;
            end
        endcase

        case (state_s)
            TX_START:  serial_s = 1'b0;
            TX_DATA:   serial_s = shreg_s[0];
            TX_PARITY: serial_s = parity_bit(par_s, PARITY);
            default:   serial_s = 1'b1;
        endcase
        active_s = (state_s != TX_IDLE);
        done_s   = (state_s == TX_STOP) && (baud_s == BAUD_LAST) && (bit_s == STOP_LAST);
    end

    // FSM, counters, shift register and registered line outputs
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= TX_IDLE;
            baud_r   <= BAUD_ZERO;
            bit_r    <= 3'd0;
            shreg_r  <= {DATA_BITS{1'b0}};
            par_r    <= 1'b0;
            serial_r <= 1'b1;
            active_r <= 1'b0;
            done_r   <= 1'b0;
            avail_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            baud_r   <= baud_s;
            bit_r    <= bit_s;
            shreg_r  <= shreg_s;
            par_r    <= par_s;
            serial_r <= serial_s;
            active_r <= active_s;
            done_r   <= done_s;
            avail_r  <= !fifo_empty_s;
            ovf_r    <= i_TX_DV && fifo_full_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level reference model, vector tables and directed corner cases.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 40;

    logic clk48 = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk48 = ~clk48;

    logic       tx_dv   = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       ready, ovf, serial, active, done;
    logic [2:0] count;

    logic       dv7   = 1'b0;
    logic [6:0] byte7 = 7'h00;
    logic       ready_e, ovf_e, serial_e, active_e, done_e;
    logic       ready_o, ovf_o, serial_o, active_o, done_o;
    logic [2:0] count_e, count_o;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk48(clk48), .rst_n(rst_n), .i_TX_DV(tx_dv), .i_TX_Byte(tx_byte),
        .o_TX_Ready(ready), .o_TX_Overflow(ovf), .o_FIFO_Count(count),
        .o_TX_Serial(serial), .o_TX_Active(active), .o_TX_Done(done));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_even (
        .clk48(clk48), .rst_n(rst_n), .i_TX_DV(dv7), .i_TX_Byte(byte7),
        .o_TX_Ready(ready_e), .o_TX_Overflow(ovf_e), .o_FIFO_Count(count_e),
        .o_TX_Serial(serial_e), .o_TX_Active(active_e), .o_TX_Done(done_e));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_odd (
        .clk48(clk48), .rst_n(rst_n), .i_TX_DV(dv7), .i_TX_Byte(byte7),
        .o_TX_Ready(ready_o), .o_TX_Overflow(ovf_o), .o_FIFO_Count(count_o),
        .o_TX_Serial(serial_o), .o_TX_Active(active_o), .o_TX_Done(done_o));

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: accepted bytes with their write edge, and the frame currently on the line
    typedef struct { int t; logic [7:0] d; } ent_t;
    ent_t       pend[$];
    int         cur_start = -1000;
    logic [7:0] cur_data  = 8'h00;
    logic       ovf_exp   = 1'b0;
    logic       model_acc;

    typedef struct { int off; logic s; logic a; logic d; } vec_t;
    vec_t v2 [12];
    typedef struct { int idx; logic even_b; logic odd_b; } pvec_t;
    pvec_t v5 [11];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        return 1'b1;
    endfunction

    task automatic wr(input logic [7:0] b);
        tx_dv   = 1'b1;
        tx_byte = b;
        @(negedge clk48);
        tx_dv   = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk48);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((pend.size() != 0 || cyc < cur_start + FRAME + 1) && g < 2000) begin
            @(negedge clk48);
            g++;
        end
    endtask

    // Model update at each rising edge: acceptance uses the count before this edge
    initial forever begin
        @(posedge clk48);
        cyc++;
        if (!rst_n) begin
            pend.delete();
            cur_start = -1000;
            ovf_exp   = 1'b0;
        end else begin
            model_acc = tx_dv && (pend.size() < DEPTH);
            ovf_exp   = tx_dv && !model_acc;
            if (pend.size() > 0 && cyc >= pend[0].t + 2 && cyc >= cur_start + FRAME) begin
                cur_start = cyc;
                cur_data  = pend[0].d;
                void'(pend.pop_front());
            end
            if (model_acc) pend.push_back(ent_t'{cyc, tx_byte});
        end
    end

    // Continuous comparison of every main-DUT output against the model
    initial forever begin
        int         d;
        logic       inf;
        logic [7:0] exp_v;
        @(negedge clk48);
        if (!rst_n) begin
            exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        end else begin
            d     = cyc - cur_start;
            inf   = (d >= 0) && (d < FRAME);
            exp_v = {inf ? frame_bit(cur_data, d / CPB) : 1'b1, inf, inf && (d == FRAME - 1),
                     pend.size() < DEPTH, ovf_exp, 3'(pend.size())};
        end
        chk("model_outputs", {8'h00, serial, active, done, ready, ovf, count}, {8'h00, exp_v});
    end

    initial begin
        int w;
        logic [7:0] b4 [6];
        logic [2:0] c4 [6];
        logic       r4 [6];
        logic       o4 [6];

        v2 = '{'{1, 1'b1, 1'b0, 1'b0}, '{2, 1'b0, 1'b1, 1'b0}, '{5, 1'b0, 1'b1, 1'b0},
               '{6, 1'b0, 1'b1, 1'b0}, '{10, 1'b1, 1'b1, 1'b0}, '{14, 1'b0, 1'b1, 1'b0},
               '{30, 1'b1, 1'b1, 1'b0}, '{34, 1'b0, 1'b1, 1'b0}, '{38, 1'b1, 1'b1, 1'b0},
               '{40, 1'b1, 1'b1, 1'b0}, '{41, 1'b1, 1'b1, 1'b1}, '{42, 1'b1, 1'b0, 1'b0}};
        v5 = '{'{0, 1'b0, 1'b0}, '{1, 1'b1, 1'b1}, '{2, 1'b0, 1'b0}, '{3, 1'b0, 1'b0},
               '{4, 1'b0, 1'b0}, '{5, 1'b0, 1'b0}, '{6, 1'b0, 1'b0}, '{7, 1'b1, 1'b1},
               '{8, 1'b0, 1'b1}, '{9, 1'b1, 1'b1}, '{10, 1'b1, 1'b1}};
        b4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hEE};
        c4 = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
        r4 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        o4 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values on all three instances
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk48);
        chk("rst_serial", {15'd0, serial}, 16'd1);
        chk("rst_active", {15'd0, active}, 16'd0);
        chk("rst_count", {13'd0, count}, 16'd0);
        chk("rst_ready", {15'd0, ready}, 16'd1);
        chk("rst_7bit", {4'd0, serial_e, serial_o, active_e, active_o, done_e, done_o,
                         ovf_e, ovf_o, ready_e, ready_o, count_e | count_o},
            {4'd0, 2'b11, 4'b0000, 2'b00, 2'b11, 3'd0});
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk48);
            chk("idle_serial", {15'd0, serial}, 16'd1);
        end

        // 8N1 frame of 0x42 checked against a table of offsets from the write edge
        w = cyc + 1;
        wr(8'h42);
        for (int i = 0; i < 12; i++) begin
            wait_until(w + v2[i].off);
            chk("b42_vector", {13'd0, serial, active, done}, {13'd0, v2[i].s, v2[i].a, v2[i].d});
        end
        wait_idle();

        // Burst of three back-to-back frames
        w = cyc + 1;
        wr(8'h55); chk("burst_cnt0", {13'd0, count}, 16'd1);
        wr(8'hAA); chk("burst_cnt1", {13'd0, count}, 16'd2);
        wr(8'h0F); chk("burst_cnt2", {13'd0, count}, 16'd2);
        wait_until(w + 41);  chk("burst_done1", {15'd0, done}, 16'd1);
        wait_until(w + 42);  chk("burst_gap1", {13'd0, serial, done, active}, {13'd0, 3'b001});
        chk("burst_cnt3", {13'd0, count}, 16'd1);
        wait_until(w + 81);  chk("burst_done2", {15'd0, done}, 16'd1);
        wait_until(w + 82);  chk("burst_cnt4", {13'd0, count}, 16'd0);
        chk("burst_gap2", {15'd0, serial}, 16'd0);
        wait_until(w + 121); chk("burst_done3", {15'd0, done}, 16'd1);
        wait_until(w + 122); chk("burst_end", {14'd0, serial, active}, {14'd0, 2'b10});
        wait_idle();

        // Overflow: six writes into a depth-4 FIFO, the sixth is rejected
        for (int i = 0; i < 6; i++) begin
            wr(b4[i]);
            chk("ovf_count", {13'd0, count}, {13'd0, c4[i]});
            chk("ovf_ready_flag", {14'd0, ready, ovf}, {14'd0, r4[i], o4[i]});
        end
        @(negedge clk48);
        chk("ovf_pulse_end", {15'd0, ovf}, 16'd0);
        wait_idle();

        // 7-bit data with even and odd parity and two stop bits
        w     = cyc + 1;
        dv7   = 1'b1;
        byte7 = 7'h41;
        @(negedge clk48);
        dv7   = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wait_until(w + 4 + 4 * v5[i].idx);
            chk("par_bits", {14'd0, serial_e, serial_o}, {14'd0, v5[i].even_b, v5[i].odd_b});
        end
        wait_until(w + 44); chk("par_done_early", {14'd0, done_e, done_o}, 16'd0);
        wait_until(w + 45); chk("par_done", {12'd0, done_e, done_o, active_e, active_o}, {12'd0, 4'b1111});
        wait_until(w + 46); chk("par_end", {14'd0, active_e, active_o}, 16'd0);

        // Reset during data bit 3 with two bytes still queued
        wait_idle();
        w = cyc + 1;
        wr(8'h42);
        wr(8'h11);
        wr(8'h22);
        wait_until(w + 19);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_line", {12'd0, serial, active, done, ready}, {12'd0, 4'b1001});
        chk("midrst_count", {13'd0, count}, 16'd0);
        repeat (3) @(negedge clk48);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk48);
            chk("post_rst_idle", {14'd0, serial, active}, {14'd0, 2'b10});
        end
        wr(8'h5A);
        wait_idle();

        // Randomized traffic, light then heavy enough to overflow
        for (int i = 0; i < 3000; i++) begin
            tx_dv   = ($urandom_range(0, 99) < ((i < 1500) ? 4 : 45));
            tx_byte = 8'($urandom);
            @(negedge clk48);
        end
        tx_dv = 1'b0;
        wait_idle();
        @(negedge clk48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
